// File: rtl/bus_master_ctrl.sv
// Single-master bus sequencer: request/grant handshake, one address strobe per access,
// slave-ready wait with timeout, and error abort on timeout or lost grant.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | no access; core_req latches the next access
// S_REQ  | bus_req_ low, waiting for arbiter grant
// S_ADDR | bus_as_ low for this single cycle, completion checks active
// S_WAIT | strobe released, waiting for bus_rdy_ / grant loss / timeout
module bus_master_ctrl #(
   parameter int ADDR_W     = 30,
   parameter int DATA_W     = 32,
   parameter int TMO_CYCLES = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_rw,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wr_data,
   output logic [DATA_W-1:0] core_rd_data,
   output logic              core_ack,
   output logic              core_err,
   output logic              core_busy,
   output logic              bus_req_,
   input  logic              bus_grnt_,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_as_,
   output logic              bus_rw,
   output logic [DATA_W-1:0] bus_wr_data,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy_
);

   localparam int              CNT_W    = $clog2(TMO_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_ADDR = 2'd2,
      S_WAIT = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] tmo_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         tmo_cnt      <= '0;
         bus_req_     <= 1'b1;
         bus_as_      <= 1'b1;
         bus_rw       <= 1'b1;
         bus_addr     <= '0;
         bus_wr_data  <= '0;
         core_rd_data <= '0;
         core_ack     <= 1'b0;
         core_err     <= 1'b0;
         core_busy    <= 1'b0;
      end else begin
         core_ack <= 1'b0;
         core_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (core_req) begin
                  bus_rw      <= core_rw;
                  bus_addr    <= core_addr;
                  bus_wr_data <= core_wr_data;
                  bus_req_    <= 1'b0;
                  core_busy   <= 1'b1;
                  state       <= S_REQ;
               end
            end
            S_REQ: begin
               if (!bus_grnt_) begin
                  bus_as_ <= 1'b0;
                  tmo_cnt <= '0;
                  state   <= S_ADDR;
               end
            end
            S_ADDR, S_WAIT: begin
               bus_as_ <= 1'b1;
               // Slave ready outranks grant loss, which outranks the timeout.
               if (!bus_rdy_ || bus_grnt_ || (tmo_cnt == CNT_LAST)) begin
                  core_ack  <= 1'b1;
                  bus_req_  <= 1'b1;
                  core_busy <= 1'b0;
                  tmo_cnt   <= '0;
                  state     <= S_IDLE;
                  if (!bus_rdy_) begin
                     core_err     <= 1'b0;
                     core_rd_data <= bus_rw ? bus_rd_data : '0;
                  end else begin
                     core_err     <= 1'b1;
                     core_rd_data <= '0;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
                  state   <= S_WAIT;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
